// File: rtl/score_scheduler.sv
// score_scheduler: holds both Pong scores and time-shares one BinaryToBCD converter between them (optional win detection under SCORE_WIN_DETECT_EN)
module score_scheduler #(
    parameter int INPUT_LENGTH = 8,
    parameter int N_DIGITS     = 2,
    parameter int WIN_SCORE    = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    goal_p0,
    input  logic                    goal_p1,
    input  logic                    clear,
    output logic                    conv_start,
    output logic [INPUT_LENGTH-1:0] conv_binary,
    input  logic [N_DIGITS*4-1:0]   conv_bcd,
    input  logic                    conv_completed,
    output logic [INPUT_LENGTH-1:0] score_p0,
    output logic [INPUT_LENGTH-1:0] score_p1,
    output logic [N_DIGITS*4-1:0]   bcd_p0,
    output logic [N_DIGITS*4-1:0]   bcd_p1,
    output logic                    busy,
    output logic                    game_over,
    output logic                    winner
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                  r_state, w_next;
    logic [INPUT_LENGTH-1:0] r_score_p0, r_score_p1, r_conv_binary, w_nxt0, w_nxt1;
    logic [N_DIGITS*4-1:0]   r_bcd_p0, r_bcd_p1;
    logic [1:0]              r_pending, w_set, w_clr;
    logic                    r_sel, r_last, r_busy, w_pick, w_launch, w_inc0, w_inc1;

    assign w_nxt0 = r_score_p0 + INPUT_LENGTH'(1);
    assign w_nxt1 = r_score_p1 + INPUT_LENGTH'(1);

`ifdef SCORE_WIN_DETECT_EN
    localparam logic [INPUT_LENGTH-1:0] WIN = INPUT_LENGTH'(WIN_SCORE);
    logic r_game_over, r_winner, w_win0, w_win1;
    assign w_inc0 = goal_p0 & ~clear & ~r_game_over;
    assign w_inc1 = goal_p1 & ~clear & ~r_game_over;
    assign w_win0 = w_inc0 && (w_nxt0 == WIN);
    assign w_win1 = w_inc1 && (w_nxt1 == WIN);
    // Latch the winner on the increment that reaches WIN_SCORE; player 0 wins a tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else if (clear) begin
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else if (!r_game_over && (w_win0 || w_win1)) begin
            r_game_over <= 1'b1;
            r_winner    <= ~w_win0;
        end
    end
    assign game_over = r_game_over;
    assign winner    = r_winner;
`else
    assign w_inc0    = goal_p0 & ~clear;
    assign w_inc1    = goal_p1 & ~clear;
    assign game_over = 1'b0;
    assign winner    = 1'b0;
`endif

    // Clear re-queues both players; a goal re-queues its player even mid-conversion
    assign w_set  = {2{clear}} | {w_inc1, w_inc0};
    assign w_pick = &r_pending ? ~r_last : r_pending[1];
    assign w_clr  = w_launch ? (w_pick ? 2'b10 : 2'b01) : 2'b00;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and converter handshake
    always_comb begin
        w_next     = r_state;
        conv_start = 1'b0;
        w_launch   = 1'b0;
        case (r_state)
            IDLE: begin
                w_launch = |r_pending;
                w_next   = w_launch ? START : IDLE;
            end
            START: begin
                conv_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT:    w_next = conv_completed ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // Scores, pending flags, operand capture and BCD result latching
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_score_p0    <= '0;
            r_score_p1    <= '0;
            r_pending     <= '0;
            r_busy        <= 1'b0;
            r_sel         <= 1'b0;
            r_last        <= 1'b0;
            r_conv_binary <= '0;
            r_bcd_p0      <= '0;
            r_bcd_p1      <= '0;
        end else begin
            r_score_p0 <= clear ? '0 : (w_inc0 ? w_nxt0 : r_score_p0);
            r_score_p1 <= clear ? '0 : (w_inc1 ? w_nxt1 : r_score_p1);
            r_pending  <= (r_pending & ~w_clr) | w_set;
            r_busy     <= w_next != IDLE;
            if (w_launch) begin
                r_sel         <= w_pick;
                r_conv_binary <= w_pick ? r_score_p1 : r_score_p0;
            end
            if (r_state == WAIT && conv_completed) begin
                r_last <= r_sel;
                if (r_sel) r_bcd_p1 <= conv_bcd;
                else       r_bcd_p0 <= conv_bcd;
            end
        end
    end

    assign conv_binary = r_conv_binary;
    assign score_p0    = r_score_p0;
    assign score_p1    = r_score_p1;
    assign bcd_p0      = r_bcd_p0;
    assign bcd_p1      = r_bcd_p1;
    assign busy        = r_busy;
endmodule

// File: tb/tb_score_scheduler.sv
// tb_score_scheduler: scoreboard bench for score_scheduler with a fixed-latency BCD converter model
module tb_score_scheduler;
    localparam int LAT = 10;

    logic       clock = 1'b0, reset = 1'b0;
    logic       goal_p0 = 1'b0, goal_p1 = 1'b0, clear = 1'b0;
    logic       conv_start, conv_completed = 1'b0;
    logic [7:0] conv_binary, conv_bcd = 8'h00;
    logic [7:0] score_p0, score_p1, bcd_p0, bcd_p1;
    logic       busy, game_over, winner;

    int         n_vec = 0, n_err = 0;
    int         cv_cnt = 0;
    logic [7:0] cv_op = 8'h00;
    bit         scb_on = 1'b0;
    logic [7:0] exp_q[$];

    score_scheduler dut (
        .clock(clock), .reset(reset), .goal_p0(goal_p0), .goal_p1(goal_p1), .clear(clear),
        .conv_start(conv_start), .conv_binary(conv_binary), .conv_bcd(conv_bcd),
        .conv_completed(conv_completed), .score_p0(score_p0), .score_p1(score_p1),
        .bcd_p0(bcd_p0), .bcd_p1(bcd_p1), .busy(busy), .game_over(game_over), .winner(winner)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] to_bcd(input int v);
        int t = (v % 100) / 10;
        int o = v % 10;
        return {t[3:0], o[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Converter model and operand scoreboard, both evaluated away from the rising edge
    always @(negedge clock) begin
        conv_completed = 1'b0;
        if (cv_cnt > 0) begin
            cv_cnt--;
            if (cv_cnt == 0) begin
                conv_completed = 1'b1;
                conv_bcd       = to_bcd(int'(cv_op));
            end
        end
        if (conv_start) begin
            cv_op  = conv_binary;
            cv_cnt = LAT;
            if (scb_on) begin
                if (exp_q.size() == 0) chk("scb_unexpected_start", 32'(conv_binary), 32'hFFFF);
                else                   chk("scb_operand", 32'(conv_binary), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        scb_on = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        run(LAT + 2);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clock);
            seen = conv_completed;
        end
        #1;
        if (!seen) chk("timeout_completed", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_score_p0", 32'(score_p0), 0);
        chk("rst_score_p1", 32'(score_p1), 0);
        chk("rst_bcd_p0", 32'(bcd_p0), 0);
        chk("rst_bcd_p1", 32'(bcd_p1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_conv_start", 32'(conv_start), 0);
        chk("rst_conv_binary", 32'(conv_binary), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_winner", 32'(winner), 0);

        // single goal: launch two cycles after the pulse with operand 1
        scb_on = 1'b1;
        exp_q.push_back(8'd1);
        goal_p0 = 1'b1;
        run(1);
        goal_p0 = 1'b0;
        chk("g1_score_p0", 32'(score_p0), 1);
        chk("g1_start_early", 32'(conv_start), 0);
        run(1);
        chk("g1_start", 32'(conv_start), 1);
        chk("g1_binary", 32'(conv_binary), 1);
        chk("g1_busy_start", 32'(busy), 1);
        run(1);
        chk("g1_start_once", 32'(conv_start), 0);
        chk("g1_busy_wait", 32'(busy), 1);
        wait_done();
        chk("g1_bcd_p0", 32'(bcd_p0), 32'h01);
        chk("g1_busy_done", 32'(busy), 0);

        // simultaneous goals with last_served=0: player 1 first
        do_reset();
        scb_on = 1'b1;
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd1);
        goal_p0 = 1'b1;
        goal_p1 = 1'b1;
        run(1);
        goal_p0 = 1'b0;
        goal_p1 = 1'b0;
        chk("sim_score_p0", 32'(score_p0), 1);
        chk("sim_score_p1", 32'(score_p1), 1);
        wait_done();
        chk("sim_first_bcd_p1", 32'(bcd_p1), 32'h01);
        chk("sim_first_bcd_p0", 32'(bcd_p0), 32'h00);
        wait_done();
        chk("sim_second_bcd_p0", 32'(bcd_p0), 32'h01);
        chk("sim_queue_empty", 32'(exp_q.size()), 0);

        // goal arriving while player 0 is being converted re-queues it
        do_reset();
        scb_on = 1'b1;
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd4);
        goal_p0 = 1'b1;
        run(3);
        goal_p0 = 1'b0;
        wait_done();
        chk("wg_bcd_first", 32'(bcd_p0), 32'h01);
        run(2);
        goal_p0 = 1'b1;
        run(1);
        goal_p0 = 1'b0;
        chk("wg_score_p0", 32'(score_p0), 4);
        wait_done();
        chk("wg_bcd_stale", 32'(bcd_p0), 32'h03);
        wait_done();
        chk("wg_bcd_fresh", 32'(bcd_p0), 32'h04);
        chk("wg_queue_empty", 32'(exp_q.size()), 0);

        // clear beats a same-cycle goal and re-converts both to zero
        do_reset();
        goal_p0 = 1'b1;
        goal_p1 = 1'b1;
        run(5);
        goal_p0 = 1'b0;
        run(2);
        goal_p1 = 1'b0;
        run(80);
        chk("cl_pre_score_p0", 32'(score_p0), 5);
        chk("cl_pre_score_p1", 32'(score_p1), 7);
        chk("cl_pre_bcd_p0", 32'(bcd_p0), 32'h05);
        chk("cl_pre_bcd_p1", 32'(bcd_p1), 32'h07);
        scb_on = 1'b1;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd0);
        clear   = 1'b1;
        goal_p1 = 1'b1;
        run(1);
        clear   = 1'b0;
        goal_p1 = 1'b0;
        chk("cl_score_p0", 32'(score_p0), 0);
        chk("cl_score_p1", 32'(score_p1), 0);
        run(60);
        chk("cl_bcd_p0", 32'(bcd_p0), 32'h00);
        chk("cl_bcd_p1", 32'(bcd_p1), 32'h00);
        chk("cl_queue_empty", 32'(exp_q.size()), 0);

        // reset mid-conversion aborts; the late completion is ignored
        do_reset();
        scb_on = 1'b1;
        exp_q.push_back(8'd1);
        goal_p0 = 1'b1;
        run(1);
        goal_p0 = 1'b0;
        run(3);
        chk("ab_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("ab_busy_reset", 32'(busy), 0);
        chk("ab_score_reset", 32'(score_p0), 0);
        run(2);
        reset = 1'b0;
        run(20);
        chk("ab_bcd_p0", 32'(bcd_p0), 32'h00);
        chk("ab_busy_after", 32'(busy), 0);

`ifdef SCORE_WIN_DETECT_EN
        // eleven goals win; the twelfth is masked
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            goal_p1 = 1'b1;
            run(1);
            goal_p1 = 1'b0;
            if (i == 10) chk("win_go_before", 32'(game_over), 0);
            if (i == 11) begin
                chk("win_go", 32'(game_over), 1);
                chk("win_winner", 32'(winner), 1);
            end
        end
        chk("win_score_p1", 32'(score_p1), 11);
        run(40);
        chk("win_bcd_p1", 32'(bcd_p1), 32'h11);
`else
        // scores wrap with no win detection
        do_reset();
        goal_p0 = 1'b1;
        run(256);
        goal_p0 = 1'b0;
        chk("wrap_score_p0", 32'(score_p0), 0);
        chk("wrap_score_p1", 32'(score_p1), 0);
        chk("wrap_game_over", 32'(game_over), 0);
        chk("wrap_winner", 32'(winner), 0);
        run(40);
        chk("wrap_bcd_p0", 32'(bcd_p0), 32'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
